cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter LINE_BEATS, 4, 32-bit return beats per cache-line read (rd_type 3'b100).
REQ-003 Parameter WORD_BEATS, 1, beats per uncached read (rd_type 3'b000/001/010).
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 ic_rd_req/ic_rd_type/ic_rd_addr  in  1/3/32  icache read request; ic_rd_rdy  out  1  grant.
REQ-007 ic_ret_valid/ic_ret_last/ic_ret_data  out  1/1/32  icache return beat.
REQ-008 dc_rd_req/dc_rd_type/dc_rd_addr  in  1/3/32; dc_rd_rdy  out  1; dc_ret_valid/dc_ret_last/dc_ret_data  out  1/1/32  dcache read side.
REQ-009 dc_wr_req/dc_wr_type/dc_wr_addr/dc_wr_wstrb/dc_wr_data  in  1/3/32/4/128; dc_wr_rdy  out  1  dcache write side.
REQ-010 m_rd_req/m_rd_type/m_rd_addr  out  1/3/32; m_rd_rdy  in  1; m_ret_valid/m_ret_last/m_ret_data  in  1/1/32  bridge read port.
REQ-011 m_wr_req/m_wr_type/m_wr_addr/m_wr_wstrb/m_wr_data  out  1/3/32/4/128; m_wr_rdy  in  1; m_wr_done  in  1  bridge write port, done = write response.
REQ-012 proto_err  out  1  sticky return-protocol error flag.

Function
REQ-013 Read FSM states: R_IDLE, R_REQ, R_DATA; one read outstanding at a time.
REQ-014 In R_IDLE, a requester is eligible when rd_req=1 and not hazard-blocked (REQ-022).
REQ-015 Grant: sole eligible requester wins; both eligible -> round-robin, winner = requester not granted last (after reset, dcache wins first).
REQ-016 Grant cycle: matching *_rd_rdy=1 combinationally, type/addr/owner latched, R_IDLE->R_REQ; *_rd_rdy=0 in all other states.
REQ-017 R_REQ: m_rd_req=1 with latched type/addr; m_rd_req & m_rd_rdy -> R_DATA, beat counter cleared.
REQ-018 R_DATA: m_ret_valid routed to owner's *_ret_valid same cycle (combinational), non-owner ret_valid=0; ret_data/ret_last passed through to both.
REQ-019 Each beat increments 3-bit beat counter; beat with m_ret_last=1 -> R_IDLE, grant pointer updated.
REQ-020 Expected beats = LINE_BEATS if type 3'b100 else WORD_BEATS; m_ret_last on wrong beat, missing last on expected final beat, or m_ret_valid outside R_DATA -> proto_err=1 (sticky); transition still follows m_ret_last.
REQ-021 Write FSM states: W_IDLE, W_REQ, W_WAIT; dc_wr_rdy=1 only in W_IDLE (precedes wr_req per cache contract).
REQ-022 Hazard: read blocked while write FSM not in W_IDLE and rd_addr[31:4]==buffered wr_addr[31:4]; also blocked in the cycle dc_wr_req&dc_wr_rdy with matching dc_wr_addr[31:4]; applies to both requesters.
REQ-023 W_IDLE: dc_wr_req & dc_wr_rdy latches type/addr/wstrb/128-bit data -> W_REQ.
REQ-024 W_REQ: m_wr_req=1 with buffered fields; m_wr_rdy -> W_WAIT; W_WAIT: m_wr_done -> W_IDLE.
REQ-025 Read and write FSMs independent; write accept and read grant in same cycle permitted if REQ-022 not violated.
REQ-026 m_wr_done outside W_WAIT ignored and sets proto_err.
REQ-027 Request inputs sampled only at grant/accept; changes afterwards have no effect.

Reset
REQ-028 Reset: R_IDLE, W_IDLE, grant pointer = icache-last, beat counter 0, proto_err 0.
REQ-029 Reset outputs: all *_req, *_rdy except dc_wr_rdy, *_ret_valid = 0; dc_wr_rdy = 1 after reset release; data/addr outputs 0.
REQ-030 Reset mid-transfer: in-flight read/write abandoned immediately, m_rd_req/m_wr_req drop asynchronously, later beats before next grant flag proto_err.

Structure
REQ-031 Shared package cache_arb_pkg: read/write state encodings, rd_type constants (BYTE 3'b000, HALF 3'b001, WORD 3'b010, LINE 3'b100), owner encoding.
REQ-032 One sub-module rr_arb2: 2-input round-robin arbiter with registered last-grant, used by read FSM.

Verification
REQ-033 ic and dc both request line reads (0x1C000040, 0x00010080) in R_IDLE -> dc granted first, 4 beats to dc only, then ic granted, 4 beats to ic.
REQ-034 dc write line 0x00010080 accepted, m_wr_rdy held 0 for 5 cycles, dc read 0x00010084 -> no dc_rd_rdy until cycle after m_wr_done; ic read 0x1C000000 granted meanwhile.
REQ-035 dc uncached word read (type 3'b010) 0xBFAF8000 -> single beat with m_ret_last=1, dc_ret_valid/last=1, proto_err stays 0.
REQ-036 Line read returns m_ret_last on beat 2 -> proto_err=1, FSM to R_IDLE, next grant proceeds.
REQ-037 reset asserted in R_DATA after beat 1 -> m_rd_req=0, ic/dc_ret_valid=0 immediately; after release dc_wr_rdy=1, new read granted normally.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/memory arbiter.
// Covers the read/write FSM states, the rd_type codes and the requester ids.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_WAIT = 2'd2
  } wr_state_e;

  localparam logic [2:0] RD_BYTE = 3'b000;
  localparam logic [2:0] RD_HALF = 3'b001;
  localparam logic [2:0] RD_WORD = 3'b010;
  localparam logic [2:0] RD_LINE = 3'b100;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// The last-grant register moves only when a granted read completes.
module rr_arb2
  import cache_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_owner,
  output logic       grant_valid,
  output logic       grant_owner
);

  logic last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= OWN_IC;
    end else if (done) begin
      last_q <= done_owner;
    end
  end

  // req[1] is dcache; with both asking, the one not served last wins
  assign grant_valid = |req;
  assign grant_owner = (req == 2'b11) ? ~last_q : req[1];

endmodule

// File: rtl/cache_mem_arbiter.sv
// Merges icache and dcache traffic onto one bridge.
// Reads are serialized (icache/dcache round-robin); a single write is buffered and issued independently.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int LINE_BEATS = 4,
  parameter int WORD_BEATS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ic_rd_req,
  input  logic [2:0]   ic_rd_type,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_rd_rdy,
  output logic         ic_ret_valid,
  output logic         ic_ret_last,
  output logic [31:0]  ic_ret_data,
  input  logic         dc_rd_req,
  input  logic [2:0]   dc_rd_type,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  output logic         dc_ret_valid,
  output logic         dc_ret_last,
  output logic [31:0]  dc_ret_data,
  input  logic         dc_wr_req,
  input  logic [2:0]   dc_wr_type,
  input  logic [31:0]  dc_wr_addr,
  input  logic [3:0]   dc_wr_wstrb,
  input  logic [127:0] dc_wr_data,
  output logic         dc_wr_rdy,
  output logic         m_rd_req,
  output logic [2:0]   m_rd_type,
  output logic [31:0]  m_rd_addr,
  input  logic         m_rd_rdy,
  input  logic         m_ret_valid,
  input  logic         m_ret_last,
  input  logic [31:0]  m_ret_data,
  output logic         m_wr_req,
  output logic [2:0]   m_wr_type,
  output logic [31:0]  m_wr_addr,
  output logic [3:0]   m_wr_wstrb,
  output logic [127:0] m_wr_data,
  input  logic         m_wr_rdy,
  input  logic         m_wr_done,
  output logic         proto_err
);

  localparam logic [3:0] LINE_N = 4'(LINE_BEATS);
  localparam logic [3:0] WORD_N = 4'(WORD_BEATS);

  rd_state_e      r_state;
  wr_state_e      w_state;
  logic           r_owner;
  logic [2:0]     r_type;
  logic [31:0]    r_addr;
  logic [2:0]     beat_cnt;
  logic [2:0]     w_type;
  logic [31:0]    w_addr;
  logic [3:0]     w_wstrb;
  logic [127:0]   w_data;
  logic           err_q;

  logic           wr_accept;
  logic           wr_busy;
  logic           ic_blk;
  logic           dc_blk;
  logic           grant_valid;
  logic           grant_owner;
  logic           rd_grant;
  logic           beat;
  logic           read_done;
  logic [3:0]     beat_num;
  logic [3:0]     exp_beats;
  logic           beat_err;
  logic           stray_err;
  logic           done_err;

  assign dc_wr_rdy = (w_state == W_IDLE);
  assign wr_accept = dc_wr_req && dc_wr_rdy;
  assign wr_busy   = (w_state != W_IDLE);

  // A read may not pass a buffered or just-accepted write to the same 16-byte line
  assign ic_blk = (wr_busy && (ic_rd_addr[31:4] == w_addr[31:4])) ||
                  (wr_accept && (ic_rd_addr[31:4] == dc_wr_addr[31:4]));
  assign dc_blk = (wr_busy && (dc_rd_addr[31:4] == w_addr[31:4])) ||
                  (wr_accept && (dc_rd_addr[31:4] == dc_wr_addr[31:4]));

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({dc_rd_req && !dc_blk, ic_rd_req && !ic_blk}),
    .done        (read_done),
    .done_owner  (r_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign rd_grant  = (r_state == R_IDLE) && grant_valid;
  assign ic_rd_rdy = rd_grant && (grant_owner == OWN_IC);
  assign dc_rd_rdy = rd_grant && (grant_owner == OWN_DC);

  assign m_rd_req  = (r_state == R_REQ);
  assign m_rd_type = r_type;
  assign m_rd_addr = r_addr;

  assign beat         = (r_state == R_DATA) && m_ret_valid;
  assign read_done    = beat && m_ret_last;
  assign ic_ret_valid = beat && (r_owner == OWN_IC);
  assign dc_ret_valid = beat && (r_owner == OWN_DC);
  assign ic_ret_last  = m_ret_last;
  assign dc_ret_last  = m_ret_last;
  assign ic_ret_data  = m_ret_data;
  assign dc_ret_data  = m_ret_data;

  // Last must land exactly on the expected beat count; beats at or past it without last are errors
  assign beat_num  = 4'(beat_cnt) + 4'd1;
  assign exp_beats = (r_type == RD_LINE) ? LINE_N : WORD_N;
  assign beat_err  = beat && (m_ret_last ? (beat_num != exp_beats) : (beat_num >= exp_beats));
  assign stray_err = m_ret_valid && (r_state != R_DATA);
  assign done_err  = m_wr_done && (w_state != W_WAIT);

  assign m_wr_req   = (w_state == W_REQ);
  assign m_wr_type  = w_type;
  assign m_wr_addr  = w_addr;
  assign m_wr_wstrb = w_wstrb;
  assign m_wr_data  = w_data;
  assign proto_err  = err_q;

  // Read FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= R_IDLE;
      r_owner  <= OWN_IC;
      r_type   <= 3'b000;
      r_addr   <= 32'h0;
      beat_cnt <= 3'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_grant) begin
            r_owner <= grant_owner;
            r_type  <= (grant_owner == OWN_DC) ? dc_rd_type : ic_rd_type;
            r_addr  <= (grant_owner == OWN_DC) ? dc_rd_addr : ic_rd_addr;
            r_state <= R_REQ;
          end
        end
        R_REQ: begin
          if (m_rd_rdy) begin
            beat_cnt <= 3'd0;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_ret_valid) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (m_ret_last) begin
              r_state <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_type  <= 3'b000;
      w_addr  <= 32'h0;
      w_wstrb <= 4'h0;
      w_data  <= 128'h0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_accept) begin
            w_type  <= dc_wr_type;
            w_addr  <= dc_wr_addr;
            w_wstrb <= dc_wr_wstrb;
            w_data  <= dc_wr_data;
            w_state <= W_REQ;
          end
        end
        W_REQ:   if (m_wr_rdy)  w_state <= W_WAIT;
        W_WAIT:  if (m_wr_done) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Sticky protocol error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (beat_err || stray_err || done_err) begin
      err_q <= 1'b1;
    end
  end

endmodule
